// File: rtl/fmap_pad_streamer.sv
// Captures one S x S feature map (all channels per beat) and replays it as a
// zero-padded (S+2P) x (S+2P) raster stream, one pixel per cycle, with no stalls.
module fmap_pad_streamer #(
  parameter int N          = 16,
  parameter int CHANNEL    = 3,
  parameter int INPUT_SIZE = 6,
  parameter int PADDING    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 input_vld,
  input  logic [CHANNEL*N-1:0] input_din,
  output logic [CHANNEL*N-1:0] dout,
  output logic                 dout_vld,
  output logic                 dout_end,
  output logic                 busy,
  output logic                 ovf_err
);

  localparam int W      = CHANNEL * N;
  localparam int S      = INPUT_SIZE;
  localparam int P      = PADDING;
  localparam int D      = S + 2 * P;
  localparam int DEPTH  = S * S;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int POS_W  = (D > 1) ? $clog2(D) : 1;

  localparam logic [ADDR_W-1:0] LAST_WR  = ADDR_W'(DEPTH - 1);
  localparam logic [POS_W-1:0]  LAST_POS = POS_W'(D - 1);

  typedef enum logic {
    CAPTURE = 1'b0,
    SEND    = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [POS_W-1:0]  row_q, row_d;
  logic [POS_W-1:0]  col_q, col_d;
  logic [W-1:0]      dout_d;
  logic              dout_vld_d;
  logic              dout_end_d;
  logic              ovf_err_d;
  logic              wr_en;

  logic [W-1:0]      mem [DEPTH];

  int                src_row;
  int                src_col;
  logic              in_window;
  logic [ADDR_W-1:0] rd_addr;

  // Map the padded raster position back onto the captured map; signed so that
  // halo positions fall outside [0, S) instead of wrapping.
  always_comb begin
    src_row   = int'(row_q) - P;
    src_col   = int'(col_q) - P;
    in_window = (src_row >= 0) && (src_row < S) && (src_col >= 0) && (src_col < S);
    rd_addr   = ADDR_W'(src_row * S + src_col);
  end

  assign busy = (state_q == SEND);

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    row_d      = row_q;
    col_d      = col_q;
    dout_d     = '0;
    dout_vld_d = 1'b0;
    dout_end_d = 1'b0;
    ovf_err_d  = ovf_err;
    wr_en      = 1'b0;

    unique case (state_q)
      CAPTURE: begin
        if (input_vld) begin
          wr_en = 1'b1;
          if (wr_cnt_q == LAST_WR) begin
            wr_cnt_d = '0;
            row_d    = '0;
            col_d    = '0;
            state_d  = SEND;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end

      SEND: begin
        // The producer cannot be stalled, so a beat arriving now is lost.
        if (input_vld) ovf_err_d = 1'b1;
        dout_vld_d = 1'b1;
        if (in_window) dout_d = mem[rd_addr];
        if (col_q == LAST_POS) begin
          col_d = '0;
          if (row_q == LAST_POS) begin
            dout_end_d = 1'b1;
            row_d      = '0;
            state_d    = CAPTURE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CAPTURE;
      wr_cnt_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      dout_end <= 1'b0;
      ovf_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      row_q    <= row_d;
      col_q    <= col_d;
      dout     <= dout_d;
      dout_vld <= dout_vld_d;
      dout_end <= dout_end_d;
      ovf_err  <= ovf_err_d;
    end
  end

  // NOTE: the frame buffer has no reset; every entry is rewritten before it is
  // read, and leaving it out of reset keeps it mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_cnt_q] <= input_din;
  end

endmodule

// File: tb/tb_fmap_pad_streamer.sv
// Scoreboard bench for fmap_pad_streamer: a 6x6/P=1 instance and a 4x4/P=0 instance
// share clock and reset; stimulus pushes expected pixels, monitors pop and compare.
module tb_fmap_pad_streamer;

  localparam int W  = 48;
  localparam int S1 = 6;
  localparam int P1 = 1;
  localparam int D1 = S1 + 2 * P1;
  localparam int T1 = D1 * D1;
  localparam int S2 = 4;
  localparam int T2 = S2 * S2;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         input_vld1, input_vld2;
  logic [W-1:0] input_din1, input_din2;
  logic [W-1:0] dout1, dout2;
  logic         dout_vld1, dout_vld2;
  logic         dout_end1, dout_end2;
  logic         busy1, busy2;
  logic         ovf_err1, ovf_err2;

  int checks = 0;
  int errors = 0;

  exp_t         q1[$];
  exp_t         q2[$];
  exp_t         e1, e2;
  logic [W-1:0] cap1[S1*S1];
  logic [W-1:0] cap2[T2];
  logic [W-1:0] rx1[T1];
  logic         rxe1[T1];
  int           beat1 = 0;

  fmap_pad_streamer #(.N(16), .CHANNEL(3), .INPUT_SIZE(S1), .PADDING(P1)) dut1 (
    .clk(clk), .rst_n(rst_n), .input_vld(input_vld1), .input_din(input_din1),
    .dout(dout1), .dout_vld(dout_vld1), .dout_end(dout_end1),
    .busy(busy1), .ovf_err(ovf_err1)
  );

  fmap_pad_streamer #(.N(16), .CHANNEL(3), .INPUT_SIZE(S2), .PADDING(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .input_vld(input_vld2), .input_din(input_din2),
    .dout(dout2), .dout_vld(dout_vld2), .dout_end(dout_end2),
    .busy(busy2), .ovf_err(ovf_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitors sample on the falling edge, half a cycle away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      beat1 = 0;
    end else if (dout_vld1) begin
      if (q1.size() == 0) begin
        check("d1_unexpected_beat", 64'd1, 64'd0);
      end else begin
        e1 = q1.pop_front();
        check("d1_data", 64'(dout1), 64'(e1.data));
        check("d1_end", 64'(dout_end1), 64'(e1.last));
      end
      if (beat1 < T1) begin
        rx1[beat1]  = dout1;
        rxe1[beat1] = dout_end1;
      end
      beat1 = dout_end1 ? 0 : beat1 + 1;
    end else begin
      check("d1_idle_zero", 64'({dout1, dout_end1}), 64'd0);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (dout_vld2) begin
        if (q2.size() == 0) begin
          check("d2_unexpected_beat", 64'd1, 64'd0);
        end else begin
          e2 = q2.pop_front();
          check("d2_data", 64'(dout2), 64'(e2.data));
          check("d2_end", 64'(dout_end2), 64'(e2.last));
        end
      end else begin
        check("d2_idle_zero", 64'({dout2, dout_end2}), 64'd0);
      end
    end
  end

  // Inputs change 2 time units after the edge; the beat is sampled on the next edge.
  task automatic drive1(input logic v, input logic [W-1:0] d);
    input_vld1 = v;
    input_din1 = d;
    @(posedge clk);
    #2;
    input_vld1 = 1'b0;
  endtask

  task automatic drive2(input logic v, input logic [W-1:0] d);
    input_vld2 = v;
    input_din2 = d;
    @(posedge clk);
    #2;
    input_vld2 = 1'b0;
  endtask

  // Expected padded raster of cap1: zero halo of width P1 around the 6x6 map.
  task automatic push_frame1();
    exp_t x;
    for (int r = 0; r < D1; r++) begin
      for (int c = 0; c < D1; c++) begin
        if (r < P1 || r >= S1 + P1 || c < P1 || c >= S1 + P1) x.data = '0;
        else x.data = cap1[(r - P1) * S1 + (c - P1)];
        x.last = (r == D1 - 1) && (c == D1 - 1);
        q1.push_back(x);
      end
    end
  endtask

  task automatic feed_frame1(input int base, input bit gaps);
    for (int i = 0; i < S1 * S1; i++) begin
      cap1[i] = {3{16'(base + i)}};
      if (gaps && (i % 2 == 1)) drive1(1'b0, 48'hDEAD_BEEF_0000);
      drive1(1'b1, cap1[i]);
    end
    push_frame1();
  endtask

  // Called right after the edge that took the last input beat (edge k).
  task automatic wait_frame1(input string name);
    bit ok = 1'b1;
    check({name, "_busy_rise"}, 64'(busy1), 64'd1);
    for (int i = 0; i < T1; i++) begin
      @(posedge clk);
      #2;
      if (!dout_vld1) ok = 1'b0;
      if ((i < T1 - 1) != busy1) ok = 1'b0;
    end
    check({name, "_vld_contig_busy"}, 64'(ok), 64'd1);
    @(posedge clk);
    #2;
    check({name, "_vld_fall"}, 64'({dout_vld1, busy1}), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q1.delete();
    q2.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int n_end;
    exp_t x;
    rst_n      = 1'b0;
    input_vld1 = 1'b0;
    input_vld2 = 1'b0;
    input_din1 = '0;
    input_din2 = '0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_outputs", 64'({dout1, dout_vld1, dout_end1, busy1, ovf_err1}), 64'd0);
    rst_n = 1'b1;

    // 1: plain 36-beat frame, pixel i = i+1 on every channel
    feed_frame1(1, 1'b0);
    wait_frame1("s1");
    check("s1_beat0_halo", 64'(rx1[0]), 64'd0);
    check("s1_beat7_halo", 64'(rx1[7]), 64'd0);
    check("s1_beat8_col0", 64'(rx1[8]), 64'd0);
    check("s1_beat9", 64'(rx1[9]), 64'(48'h0001_0001_0001));
    check("s1_beat15_col7", 64'(rx1[15]), 64'd0);
    check("s1_beat54", 64'(rx1[54]), 64'(48'h0024_0024_0024));
    check("s1_beat56_halo", 64'(rx1[56]), 64'd0);
    check("s1_beat63_halo", 64'(rx1[63]), 64'd0);
    n_end = 0;
    for (int i = 0; i < T1; i++) n_end += int'(rxe1[i]);
    check("s1_end_count", 64'(n_end), 64'd1);
    check("s1_end_beat63", 64'(rxe1[63]), 64'd1);

    // 2: same frame with input_vld toggling
    feed_frame1(1, 1'b1);
    wait_frame1("s2");
    check("s2_beat9", 64'(rx1[9]), 64'(48'h0001_0001_0001));
    check("s2_no_ovf", 64'(ovf_err1), 64'd0);

    // 3: input_vld held high for 100 cycles; beats during SEND are dropped
    for (int i = 0; i < 100; i++) begin
      if (i < S1 * S1) cap1[i] = {3{16'(i + 1)}};
      drive1(1'b1, (i < S1 * S1) ? cap1[i] : {3{16'(1000 + i)}});
      if (i == S1 * S1 - 1) push_frame1();
    end
    check("s3_ovf_set", 64'(ovf_err1), 64'd1);
    check("s3_idle_after_send", 64'(busy1), 64'd0);
    feed_frame1(101, 1'b0);
    wait_frame1("s3b");
    check("s3_ovf_sticky", 64'(ovf_err1), 64'd1);

    // 4: second frame starts on the edge right after SEND ends
    do_reset();
    feed_frame1(1, 1'b0);
    for (int i = 0; i < T1; i++) drive1(1'b0, '0);
    check("s4_busy_fell", 64'(busy1), 64'd0);
    feed_frame1(301, 1'b0);
    wait_frame1("s4");
    check("s4_no_ovf", 64'(ovf_err1), 64'd0);
    check("s4_queue_drained", 64'(q1.size()), 64'd0);

    // 5: reset during output beat 20, then a fresh frame
    feed_frame1(51, 1'b0);
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("s5_async_clear", 64'({dout1, dout_vld1, dout_end1, busy1, ovf_err1}), 64'd0);
    q1.delete();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("s5_no_residue", 64'({dout_vld1, busy1}), 64'd0);
    feed_frame1(201, 1'b0);
    wait_frame1("s5");
    check("s5_beat9", 64'(rx1[9]), 64'(48'h00C9_00C9_00C9));

    // 6: PADDING=0, S=4 replays the input in order
    for (int i = 0; i < T2; i++) begin
      cap2[i] = {16'hA000 + 16'(i), 16'h5000 + 16'(i), 16'(i * 3 + 7)};
      drive2(1'b1, cap2[i]);
    end
    for (int i = 0; i < T2; i++) begin
      x.data = cap2[i];
      x.last = (i == T2 - 1);
      q2.push_back(x);
    end
    begin
      bit ok = 1'b1;
      for (int i = 0; i < T2; i++) begin
        @(posedge clk);
        #2;
        if (!dout_vld2) ok = 1'b0;
      end
      check("s6_vld_contig", 64'(ok), 64'd1);
      @(posedge clk);
      #2;
      check("s6_vld_fall", 64'({dout_vld2, busy2}), 64'd0);
    end

    repeat (2) @(posedge clk);
    #2;
    check("final_q1_empty", 64'(q1.size()), 64'd0);
    check("final_q2_empty", 64'(q2.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
